// File: rtl/hazard_tnew_pipe_if.sv
// Purpose : groups the D-stage instruction/stall inputs and the per-stage
//           {A3, RegWr, Tnew} plus pipeline-enable outputs of hazard_tnew_pipe.
// Ports   : master drives instr_D/stall and observes the rest; slave is the pipe.
interface hazard_tnew_pipe_if;
  logic [31:0] instr_D;
  logic        stall;
  logic [4:0]  A3_E;
  logic [4:0]  A3_M;
  logic [4:0]  A3_W;
  logic        RegWr_E;
  logic        RegWr_M;
  logic        RegWr_W;
  logic [1:0]  Tnew_E;
  logic [1:0]  Tnew_M;
  logic [1:0]  Tnew_W;
  logic        en_PC;
  logic        en_D;
  logic        clr_E;

  modport master (
    output instr_D, stall,
    input  A3_E, A3_M, A3_W, RegWr_E, RegWr_M, RegWr_W,
    input  Tnew_E, Tnew_M, Tnew_W, en_PC, en_D, clr_E
  );

  modport slave (
    input  instr_D, stall,
    output A3_E, A3_M, A3_W, RegWr_E, RegWr_M, RegWr_W,
    output Tnew_E, Tnew_M, Tnew_W, en_PC, en_D, clr_E
  );
endinterface

// File: rtl/hazard_tnew_pipe.sv
// Purpose     : decodes the D instruction into {dest, write-enable, Tnew} and carries it E->M->W.
// Latency     : D record appears on E 1 cycle after a non-stalled edge, M after 2, W after 3.
// Backpressure: stall freezes PC and IF/ID (combinational) and bubbles E; M and W always drain.
// Ports       : clk, reset (sync, active-high), bus (slave modport): instr_D, stall in;
//               A3/RegWr/Tnew for E, M, W and en_PC/en_D/clr_E out.
module hazard_tnew_pipe #(
  parameter logic [4:0] RA_REG   = 5'd31,
  parameter logic [1:0] TNEW_ALU = 2'd1,
  parameter logic [1:0] TNEW_LD  = 2'd2
) (
  input logic               clk,
  input logic               reset,
  hazard_tnew_pipe_if.slave bus
);

  typedef struct packed {
    logic [4:0] a3;
    logic       regwr;
    logic [1:0] tnew;
  } stage_rec_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;

  // One stage of ageing: Tnew saturates at 0 instead of wrapping to 3.
  function automatic stage_rec_t age_rec(input stage_rec_t r);
    stage_rec_t o;
    o      = r;
    o.tnew = (r.tnew == 2'd0) ? 2'd0 : r.tnew - 2'd1;
    return o;
  endfunction

  logic [5:0] op;
  logic [5:0] func;
  logic [4:0] dest;
  logic       wr;
  logic [1:0] tn;
  stage_rec_t d_rec;
  stage_rec_t e_q;
  stage_rec_t m_q;
  stage_rec_t w_q;

  assign op   = bus.instr_D[31:26];
  assign func = bus.instr_D[5:0];

  always_comb begin
    dest = 5'd0;
    wr   = 1'b0;
    tn   = 2'd0;
    case (op)
      OP_SPECIAL: begin
        if (func == FN_ADDU || func == FN_SUBU) begin
          dest = bus.instr_D[15:11];
          wr   = 1'b1;
          tn   = TNEW_ALU;
        end
      end
      OP_ORI, OP_LUI: begin
        dest = bus.instr_D[20:16];
        wr   = 1'b1;
        tn   = TNEW_ALU;
      end
      OP_LW: begin
        dest = bus.instr_D[20:16];
        wr   = 1'b1;
        tn   = TNEW_LD;
      end
      OP_JAL: begin
        // Link value PC+8 is already known in D, so nothing is pending.
        dest = RA_REG;
        wr   = 1'b1;
        tn   = 2'd0;
      end
      default: begin
        dest = 5'd0;
        wr   = 1'b0;
        tn   = 2'd0;
      end
    endcase
  end

  // $0 is never reported as a pending write: a write to it collapses to a bubble.
  always_comb begin
    d_rec = '0;
    if (wr && dest != 5'd0) begin
      d_rec.a3    = dest;
      d_rec.regwr = 1'b1;
      d_rec.tnew  = tn;
    end
  end

  // Stall only bubbles E; older records keep draining so nothing is lost or duplicated.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= bus.stall ? stage_rec_t'('0) : d_rec;
      m_q <= age_rec(e_q);
      w_q <= age_rec(m_q);
    end
  end

  assign bus.A3_E    = e_q.a3;
  assign bus.RegWr_E = e_q.regwr;
  assign bus.Tnew_E  = e_q.tnew;
  assign bus.A3_M    = m_q.a3;
  assign bus.RegWr_M = m_q.regwr;
  assign bus.Tnew_M  = m_q.tnew;
  assign bus.A3_W    = w_q.a3;
  assign bus.RegWr_W = w_q.regwr;
  assign bus.Tnew_W  = w_q.tnew;

  assign bus.en_PC = ~bus.stall;
  assign bus.en_D  = ~bus.stall;
  assign bus.clr_E = bus.stall;

endmodule

// File: tb/tb_hazard_tnew_pipe.sv
// Bench for hazard_tnew_pipe: directed scenarios with literal expectations,
// then randomized instructions/stalls/resets checked every cycle against a
// history-of-issued-records model.
module tb_hazard_tnew_pipe;

  typedef struct {
    int a3;
    int wr;
    int tn;
  } rec_t;

  logic clk;
  logic reset;
  hazard_tnew_pipe_if bus ();

  hazard_tnew_pipe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Records that entered E at each edge, oldest first; the last three are live.
  rec_t hist[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction table.
  function automatic rec_t ref_dec(input logic [31:0] ins);
    rec_t r;
    int   op;
    int   fn;
    op   = int'(ins[31:26]);
    fn   = int'(ins[5:0]);
    r.a3 = 0; r.wr = 0; r.tn = 0;
    if (op == 0 && (fn == 'h21 || fn == 'h23)) begin
      r.a3 = int'(ins[15:11]); r.wr = 1; r.tn = 1;
    end else if (op == 'h0d || op == 'h0f) begin
      r.a3 = int'(ins[20:16]); r.wr = 1; r.tn = 1;
    end else if (op == 'h23) begin
      r.a3 = int'(ins[20:16]); r.wr = 1; r.tn = 2;
    end else if (op == 'h03) begin
      r.a3 = 31; r.wr = 1; r.tn = 0;
    end
    if (r.a3 == 0) begin
      r.wr = 0; r.tn = 0;
    end
    return r;
  endfunction

  function automatic rec_t zero_rec();
    rec_t r;
    r.a3 = 0; r.wr = 0; r.tn = 0;
    return r;
  endfunction

  // Model update: a reset empties the whole pipe, otherwise E takes D or a bubble.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        hist.push_back(zero_rec());
        hist.pop_front();
      end
    end else begin
      hist.push_back(bus.stall ? zero_rec() : ref_dec(bus.instr_D));
      hist.pop_front();
    end
  end

  // Every cycle: record k stages past E has Tnew = max(0, Tnew_at_E - k).
  always @(negedge clk) begin
    if (chk_en) begin
      chk("A3_E",    32'(bus.A3_E),    32'(hist[2].a3));
      chk("RegWr_E", 32'(bus.RegWr_E), 32'(hist[2].wr));
      chk("Tnew_E",  32'(bus.Tnew_E),  32'(hist[2].tn));
      chk("A3_M",    32'(bus.A3_M),    32'(hist[1].a3));
      chk("RegWr_M", 32'(bus.RegWr_M), 32'(hist[1].wr));
      chk("Tnew_M",  32'(bus.Tnew_M),  32'(hist[1].tn > 1 ? hist[1].tn - 1 : 0));
      chk("A3_W",    32'(bus.A3_W),    32'(hist[0].a3));
      chk("RegWr_W", 32'(bus.RegWr_W), 32'(hist[0].wr));
      chk("Tnew_W",  32'(bus.Tnew_W),  32'(hist[0].tn > 2 ? hist[0].tn - 2 : 0));
      chk("en_PC",   32'(bus.en_PC),   32'(!bus.stall));
      chk("en_D",    32'(bus.en_D),    32'(!bus.stall));
      chk("clr_E",   32'(bus.clr_E),   32'(bus.stall));
    end
  end

  task automatic drive(input logic [31:0] ins, input logic st, input logic rs);
    bus.instr_D = ins;
    bus.stall   = st;
    reset       = rs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [31:0] ins, input logic st, input logic rs);
    drive(ins, st, rs);
    tick();
  endtask

  task automatic chk_e(input string n, input int a3, input int wr, input int tn);
    chk({n, ".A3_E"},    32'(bus.A3_E),    32'(a3));
    chk({n, ".RegWr_E"}, 32'(bus.RegWr_E), 32'(wr));
    chk({n, ".Tnew_E"},  32'(bus.Tnew_E),  32'(tn));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    rs  = 5'($urandom_range(0, 31));
    rt  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    imm = 16'($urandom);
    case ($urandom_range(0, 9))
      0: return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      1: return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      2: return {6'h0d, rs, rt, imm};
      3: return {6'h0f, 5'd0, rt, imm};
      4: return {6'h23, rs, rt, imm};
      5: return {6'h03, 26'($urandom)};
      6: return {6'h2b, rs, rt, imm};
      7: return {6'h04, rs, rt, imm};
      8: return {6'h00, rs, rt, rd, 5'd0, 6'($urandom)};
      default: return 32'($urandom);
    endcase
  endfunction

  int cnt;

  initial begin
    hist.push_back(zero_rec());
    hist.push_back(zero_rec());
    hist.push_back(zero_rec());

    // 1) reset held two cycles with lw $8 in D
    step(32'h8C080000, 1'b0, 1'b1);
    step(32'h8C080000, 1'b0, 1'b1);
    chk_en = 1'b1;
    chk_e("rst", 0, 0, 0);
    chk("rst.A3_M", 32'(bus.A3_M), 0);
    chk("rst.RegWr_W", 32'(bus.RegWr_W), 0);
    chk("rst.Tnew_M", 32'(bus.Tnew_M), 0);
    step(32'h8C080000, 1'b0, 1'b0);
    chk_e("lw8", 8, 1, 2);

    // 2) addu $3,$1,$2 down the pipe
    step(32'h00221821, 1'b0, 1'b0);
    chk_e("addu3", 3, 1, 1);
    step(32'h00000000, 1'b0, 1'b0);
    chk("addu3.A3_M", 32'(bus.A3_M), 3);
    chk("addu3.Tnew_M", 32'(bus.Tnew_M), 0);
    step(32'h00000000, 1'b0, 1'b0);
    chk("addu3.A3_W", 32'(bus.A3_W), 3);
    chk("addu3.RegWr_W", 32'(bus.RegWr_W), 1);

    // 3) lw $5 then dependent addu with one stall cycle
    step(32'h8C050000, 1'b0, 1'b0);
    drive(32'h00A53021, 1'b1, 1'b0);
    #1;
    chk("stall.en_PC", 32'(bus.en_PC), 0);
    chk("stall.en_D", 32'(bus.en_D), 0);
    chk("stall.clr_E", 32'(bus.clr_E), 1);
    tick();
    chk_e("bubble", 0, 0, 0);
    chk("lw5.A3_M", 32'(bus.A3_M), 5);
    chk("lw5.Tnew_M", 32'(bus.Tnew_M), 1);
    step(32'h00A53021, 1'b0, 1'b0);
    chk("lw5.A3_W", 32'(bus.A3_W), 5);
    chk("lw5.Tnew_W", 32'(bus.Tnew_W), 0);
    chk_e("addu6", 6, 1, 1);

    // 4) jal, writes to $0 and non-writing instructions
    step(32'h0C000010, 1'b0, 1'b0);
    chk_e("jal", 31, 1, 0);
    step(32'h34000005, 1'b0, 1'b0);
    chk_e("ori0", 0, 0, 0);
    step(32'hAC050000, 1'b0, 1'b0);
    chk("sw.RegWr_E", 32'(bus.RegWr_E), 0);
    step(32'h10000003, 1'b0, 1'b0);
    chk("beq.RegWr_E", 32'(bus.RegWr_E), 0);
    step(32'h03E00008, 1'b0, 1'b0);
    chk("jr.RegWr_E", 32'(bus.RegWr_E), 0);

    // 5) lw $9 followed by three stall cycles: $9 leaves W exactly once
    step(32'h8C090000, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(32'h01294821, 1'b1, 1'b0);
      chk_e("stall3", 0, 0, 0);
      if (bus.A3_W == 5'd9 && bus.RegWr_W) cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      step(32'h00000000, 1'b0, 1'b0);
      if (bus.A3_W == 5'd9 && bus.RegWr_W) cnt++;
    end
    chk("lw9.exits_W", 32'(cnt), 1);

    // 6) reset while lw $7 sits in M
    step(32'h8C070000, 1'b0, 1'b0);
    step(32'h00000000, 1'b0, 1'b0);
    chk("lw7.A3_M", 32'(bus.A3_M), 7);
    step(32'h00000000, 1'b0, 1'b1);
    chk("rstM.A3_M", 32'(bus.A3_M), 0);
    chk("rstM.A3_W", 32'(bus.A3_W), 0);
    chk("rstM.RegWr_W", 32'(bus.RegWr_W), 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(32'h00000000, 1'b0, 1'b0);
      if (bus.A3_W == 5'd7) cnt++;
    end
    chk("lw7.reappears", 32'(cnt), 0);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      step(rand_instr(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
    end
    step(32'h00000000, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
